// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: stage record, forward codes, width helpers.
package hazard_pkg;

    // Record dest field is sized for the largest supported register file; narrower addrs zero-extend.
    localparam int REC_AW   = 8;
    localparam int FWD_NONE = 0;

    typedef struct packed {
        logic              valid;
        logic [REC_AW-1:0] dest;
        logic              reg_write;
        logic              mem_read;
    } hz_rec_t;

    function automatic int aw_of(input int num_regs);
        return (num_regs > 2) ? $clog2(num_regs) : 1;
    endfunction

    function automatic int sw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Forward code for a winning match in stage k (0 is reserved for the register file).
    function automatic int fwd_code(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side bundle between decode and the hazard scoreboard.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3
);
    localparam int AW = aw_of(NUM_REGS);
    localparam int SW = sw_of(DEPTH);

    logic                  id_valid;
    logic [AW-1:0]         id_dest;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic [NUM_SRC*AW-1:0] src_addr;
    logic [NUM_SRC-1:0]    src_use;
    logic                  hold;
    logic                  flush;
    logic                  stall;
    logic [NUM_SRC*SW-1:0] fwd_sel;

    modport master (
        output id_valid, id_dest, id_reg_write, id_mem_read, src_addr, src_use, hold, flush,
        input  stall, fwd_sel
    );

    modport slave (
        input  id_valid, id_dest, id_reg_write, id_mem_read, src_addr, src_use, hold, flush,
        output stall, fwd_sel
    );
endinterface

// File: rtl/hazard_match.sv
// Youngest-first matcher for one source operand over the in-flight stage records.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int AW         = 2,
    parameter int SW         = 2
) (
    input  logic                en,
    input  logic [AW-1:0]       addr,
    input  hz_rec_t [DEPTH-1:0] recs,
    output logic [SW-1:0]       sel,
    output logic                load_block
);
    logic found;

    always_comb begin
        sel        = SW'(FWD_NONE);
        load_block = 1'b0;
        found      = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && en && recs[k].valid && recs[k].reg_write &&
                recs[k].dest == REC_AW'(addr)) begin
                found = 1'b1;
                // Load data not yet available this early: block instead of forwarding.
                if (recs[k].mem_read && k < LOAD_STAGE) load_block = 1'b1;
                else                                    sel        = SW'(fwd_code(k));
            end
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: record pipeline EX..WB, per-operand forward selects and load-use stall.
// Define HAZARD_STATS_EN to add saturating stall_cnt / fwd_cnt statistics outputs.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS     = 4,
    parameter int NUM_SRC      = 2,
    parameter int DEPTH        = 3,
    parameter int LOAD_STAGE   = 1,
    parameter int FLUSH_STAGES = 1
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        fwd_cnt
`endif
);
    localparam int AW = aw_of(NUM_REGS);
    localparam int SW = sw_of(DEPTH);

    hz_rec_t [DEPTH-1:0]   rec;
    hz_rec_t [DEPTH-1:0]   rec_nxt;
    hz_rec_t               id_rec;
    logic [NUM_SRC-1:0]    blk;
    logic [NUM_SRC*SW-1:0] fwd;
    logic                  stall;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        hazard_match #(
            .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .AW(AW), .SW(SW)
        ) u_match (
            .en        (bus.src_use[g] & bus.id_valid),
            .addr      (bus.src_addr[g*AW +: AW]),
            .recs      (rec),
            .sel       (fwd[g*SW +: SW]),
            .load_block(blk[g])
        );
    end

    assign stall       = |blk;
    assign bus.stall   = stall;
    assign bus.fwd_sel = fwd;

    always_comb begin
        id_rec           = '0;
        id_rec.valid     = 1'b1;
        id_rec.dest      = REC_AW'(bus.id_dest);
        id_rec.reg_write = bus.id_reg_write;
        id_rec.mem_read  = bus.id_mem_read;
    end

    // Flush clears the youngest stages after the shift, or in place when frozen.
    always_comb begin
        rec_nxt = rec;
        if (!bus.hold) begin
            for (int k = DEPTH - 1; k > 0; k--) rec_nxt[k] = rec[k-1];
            if (bus.id_valid && !stall && !bus.flush) rec_nxt[0] = id_rec;
            else                                      rec_nxt[0] = '0;
        end
        if (bus.flush) begin
            for (int k = 0; k < FLUSH_STAGES; k++) rec_nxt[k].valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rec <= '0;
        else       rec <= rec_nxt;
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && !bus.hold && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (|fwd && !stall && !bus.hold && fwd_cnt != 16'hFFFF)
                fwd_cnt <= fwd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an in-flight-write list model checked every cycle.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NUM_REGS     = 4;
    localparam int NUM_SRC      = 2;
    localparam int DEPTH        = 3;
    localparam int LOAD_STAGE   = 1;
    localparam int FLUSH_STAGES = 1;
    localparam int AW           = 2;
    localparam int SW           = 2;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus ();

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, fwd_cnt;
    hazard_scoreboard_if #(.NUM_REGS(4), .NUM_SRC(2), .DEPTH(8)) sbus ();
    logic [15:0] s_stall_cnt, s_fwd_cnt;
    hazard_scoreboard #(
        .NUM_REGS(4), .NUM_SRC(2), .DEPTH(8), .LOAD_STAGE(7), .FLUSH_STAGES(1)
    ) u_sat (
        .clk(clk), .reset(reset), .bus(sbus), .stall_cnt(s_stall_cnt), .fwd_cnt(s_fwd_cnt)
    );
`endif

    hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
        .LOAD_STAGE(LOAD_STAGE), .FLUSH_STAGES(FLUSH_STAGES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .fwd_cnt  (fwd_cnt)
`endif
    );

    // Model: a list of in-flight writers, each with its age in advancing edges since issue.
    typedef struct {
        int dest;
        bit rw;
        bit mr;
        int age;
    } ent_t;

    ent_t inflight[$];
    int   m_stall_cnt = 0;
    int   m_fwd_cnt   = 0;

    function automatic void model_eval(output bit st, output logic [NUM_SRC*SW-1:0] fs);
        st = 1'b0;
        fs = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            int best;
            bit ld;
            best = -1;
            ld   = 1'b0;
            if (bus.src_use[i] && bus.id_valid) begin
                foreach (inflight[j]) begin
                    if (inflight[j].rw && inflight[j].dest == int'(bus.src_addr[i*AW +: AW]) &&
                        (best < 0 || inflight[j].age < best)) begin
                        best = inflight[j].age;
                        ld   = inflight[j].mr;
                    end
                end
            end
            if (best >= 0) begin
                if (ld && best < LOAD_STAGE) st = 1'b1;
                else                         fs[i*SW +: SW] = SW'(best + 1);
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        bit st;
        logic [NUM_SRC*SW-1:0] fs;
        ent_t nq[$];
        ent_t e;
        if (reset) begin
            inflight.delete();
            m_stall_cnt = 0;
            m_fwd_cnt   = 0;
        end else begin
            model_eval(st, fs);
            if (st && !bus.hold && m_stall_cnt < 65535) m_stall_cnt++;
            if (fs != '0 && !st && !bus.hold && m_fwd_cnt < 65535) m_fwd_cnt++;
            nq.delete();
            foreach (inflight[j]) begin
                e = inflight[j];
                if (!bus.hold) e.age++;
                if (e.age < DEPTH && !(bus.flush && e.age < FLUSH_STAGES)) nq.push_back(e);
            end
            if (!bus.hold && bus.id_valid && !st && !bus.flush) begin
                e.dest = int'(bus.id_dest);
                e.rw   = bus.id_reg_write;
                e.mr   = bus.id_mem_read;
                e.age  = 0;
                nq.push_front(e);
            end
            inflight = nq;
        end
    end

    always @(negedge clk) begin
        bit st;
        logic [NUM_SRC*SW-1:0] fs;
        model_eval(st, fs);
        total++;
        if (bus.stall !== st || bus.fwd_sel !== fs) begin
            bad++;
            $display("FAIL model_cycle t=%0t stall=%b fwd_sel=%h expected stall=%b fwd_sel=%h",
                     $time, bus.stall, bus.fwd_sel, st, fs);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int d, input bit rw, input bit mr);
        bus.id_valid     = v;
        bus.id_dest      = AW'(d);
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
    endtask

    task automatic set_src(input int s0, input int s1, input logic [1:0] u);
        bus.src_addr = {AW'(s1), AW'(s0)};
        bus.src_use  = u;
    endtask

    task automatic bubble();
        set_id(1'b0, 0, 1'b0, 1'b0);
        set_src(0, 0, 2'b00);
    endtask

    function automatic int f0();
        return int'(bus.fwd_sel[1:0]);
    endfunction

    function automatic int f1();
        return int'(bus.fwd_sel[3:2]);
    endfunction

    initial begin
        reset     = 1'b1;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        bubble();
`ifdef HAZARD_STATS_EN
        sbus.id_valid = 1'b1; sbus.id_dest = 2'd1; sbus.id_reg_write = 1'b1;
        sbus.id_mem_read = 1'b1; sbus.src_addr = 4'b0001; sbus.src_use = 2'b01;
        sbus.hold = 1'b0; sbus.flush = 1'b0;
`endif
        repeat (2) tick();
        chk("reset_stall", bus.stall, 0);
        chk("reset_fwd", int'(bus.fwd_sel), 0);
        reset = 1'b0;

        // ALU writer r2, reader at distances 1..4
        set_id(1, 2, 1, 0); tick();
        set_id(1, 0, 0, 0); set_src(2, 0, 2'b01); #1;
        chk("alu_ex_fwd", f0(), 1);
        chk("alu_ex_stall", bus.stall, 0);
        bubble(); tick();
        set_id(1, 0, 0, 0); set_src(2, 0, 2'b01); #1;
        chk("alu_mem_fwd", f0(), 2);
        bubble(); tick();
        set_id(1, 0, 0, 0); set_src(2, 0, 2'b01); #1;
        chk("alu_wb_fwd", f0(), 3);
        bubble(); tick();
        set_id(1, 0, 0, 0); set_src(2, 0, 2'b01); #1;
        chk("alu_retired_fwd", f0(), 0);
        bubble(); tick();

        // Load r1 then reader on rt
        set_id(1, 1, 1, 1); set_src(0, 0, 2'b00); tick();
        set_id(1, 0, 0, 0); set_src(0, 1, 2'b10); #1;
        chk("ldu_stall", bus.stall, 1);
        chk("ldu_fwd_blocked", f1(), 0);
        tick();
        chk("ldu_resolved_stall", bus.stall, 0);
        chk("ldu_resolved_fwd", f1(), 2);
        bubble(); repeat (3) tick();

        // Two writers of r3 at stages 0 and 2
        set_id(1, 3, 1, 0); tick();
        bubble(); tick();
        set_id(1, 3, 1, 0); tick();
        set_id(1, 0, 0, 0); set_src(3, 0, 2'b01); #1;
        chk("dbl_youngest", f0(), 1);
        set_src(3, 0, 2'b00); #1;
        chk("dbl_unused", f0(), 0);
        bubble(); repeat (3) tick();

        // Youngest writer is a load: the older ALU match must not hide the stall
        set_id(1, 3, 1, 0); tick();
        bubble(); tick();
        set_id(1, 3, 1, 1); tick();
        set_id(1, 0, 0, 0); set_src(3, 0, 2'b01); #1;
        chk("young_load_stall", bus.stall, 1);
        chk("young_load_fwd", f0(), 0);
        bubble(); repeat (3) tick();

        // Hold for three edges during a load-use stall
        set_id(1, 1, 1, 1); set_src(0, 0, 2'b00); tick();
        set_id(1, 0, 0, 0); set_src(0, 1, 2'b10); bus.hold = 1'b1; #1;
        chk("hold_stall_0", bus.stall, 1);
        repeat (3) begin
            tick();
            chk("hold_stall", bus.stall, 1);
        end
        bus.hold = 1'b0; #1;
        chk("hold_release_stall", bus.stall, 1);
        tick();
        chk("hold_after_stall", bus.stall, 0);
        chk("hold_after_fwd", f1(), 2);
        bubble(); repeat (3) tick();

        // Flush on the issuing cycle of an r1 writer
        set_id(1, 1, 1, 0); bus.flush = 1'b1; tick();
        bus.flush = 1'b0; set_id(1, 0, 0, 0); set_src(1, 0, 2'b01); #1;
        chk("flush_issue_fwd", f0(), 0);
        set_id(1, 2, 1, 0); set_src(0, 0, 2'b00); tick();
        bubble(); bus.hold = 1'b1; bus.flush = 1'b1; tick();
        bus.hold = 1'b0; bus.flush = 1'b0;
        set_id(1, 0, 0, 0); set_src(2, 0, 2'b01); #1;
        chk("flush_hold_fwd", f0(), 0);
        bubble(); tick();

        // Reset mid-stall, then capture on the first edge after release
        set_id(1, 1, 1, 1); set_src(0, 0, 2'b00); tick();
        set_id(1, 0, 0, 0); set_src(0, 1, 2'b10); #1;
        chk("pre_reset_stall", bus.stall, 1);
        reset = 1'b1; #1;
        chk("reset_mid_stall", bus.stall, 0);
        chk("reset_mid_fwd", int'(bus.fwd_sel), 0);
        tick();
        reset = 1'b0;
        set_id(1, 2, 1, 0); set_src(0, 0, 2'b00); tick();
        set_id(1, 0, 0, 0); set_src(2, 2, 2'b11); #1;
        chk("post_reset_both_fwd", int'(bus.fwd_sel), 5);
        bubble(); repeat (3) tick();

`ifdef HAZARD_STATS_EN
        chk("stall_cnt", int'(stall_cnt), m_stall_cnt);
        chk("fwd_cnt", int'(fwd_cnt), m_fwd_cnt);
        repeat (76000) @(posedge clk);
        #1;
        chk("sat_stall_cnt", int'(s_stall_cnt), 65535);
        repeat (50) @(posedge clk);
        #1;
        chk("sat_stall_cnt_hold", int'(s_stall_cnt), 65535);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
